// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, RV32I opcode/funct fields and the ALU instruction decoder.
// Define ALU_DECODE_SLT_EN to also decode slt/slti.
package alu_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        logic       legal;
        logic       is_r;
        logic [3:0] ctrl;
    } dec_t;

    function automatic dec_t alu_decode(input logic [31:0] instr);
        dec_t d;
        logic r, i, base_ok, sub_ok;
        r = instr[6:0] == OP_REG;
        i = instr[6:0] == OP_IMM;
        base_ok = i || (r && instr[31:25] == F7_BASE);
        sub_ok = r && instr[31:25] == F7_SUB;
        d.is_r = r;
        d.ctrl = ALU_AND;
        d.legal = 1'b0;
        case (instr[14:12])
            F3_ADD: begin
                d.ctrl = sub_ok ? ALU_SUB : ALU_ADD;
                d.legal = base_ok || sub_ok;
            end
            F3_OR: begin
                d.ctrl = ALU_OR;
                d.legal = base_ok;
            end
            F3_AND: begin
                d.ctrl = ALU_AND;
                d.legal = base_ok;
            end
`ifdef ALU_DECODE_SLT_EN
            F3_SLT: begin
                d.ctrl = ALU_SLT;
                d.legal = base_ok;
            end
`endif
            default: ;
        endcase
        return d;
    endfunction
endpackage

// File: rtl/alu_decode_stage_if.sv
// alu_decode_stage_if: instruction, ALU issue and writeback signals of the decode stage.
interface alu_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            InstrValid;
    logic            InstrReady;
    logic [31:0]     Instr;
    logic            AluValid;
    logic            AluReady;
    logic [3:0]      Control;
    logic [XLEN-1:0] Operand1;
    logic [XLEN-1:0] Operand2;
    logic [4:0]      Rd;
    logic            WbEn;
    logic [4:0]      WbAddr;
    logic [XLEN-1:0] WbData;
    logic            IllegalInstr;

    modport master (
        output InstrValid, Instr, AluReady, WbEn, WbAddr, WbData,
        input  InstrReady, AluValid, Control, Operand1, Operand2, Rd, IllegalInstr
    );
    modport slave (
        input  InstrValid, Instr, AluReady, WbEn, WbAddr, WbData,
        output InstrReady, AluValid, Control, Operand1, Operand2, Rd, IllegalInstr
    );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: 2R1W register file, x0 hardwired to zero, write-through bypass on reads.
module alu_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = raddr1 == '0 ? '0 : (we && waddr == raddr1) ? wdata : regs[raddr1];
    assign rdata2 = raddr2 == '0 ? '0 : (we && waddr == raddr2) ? wdata : regs[raddr2];
endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I ALU decode/operand fetch with a RAW scoreboard on destination registers.
// Optional slt/slti support comes from ALU_DECODE_SLT_EN, evaluated in alu_pkg.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic               Clk,
    input logic               Reset,
    alu_decode_stage_if.slave bus
);
    dec_t            dec;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rdata1, rdata2, imm;
    logic [NREG-1:0] pending, pending_nx;
    logic            busy1, busy2, hazard, accept, issue;

    assign dec = alu_decode(bus.Instr);
    assign rs1 = bus.Instr[19:15];
    assign rs2 = bus.Instr[24:20];
    assign rd  = bus.Instr[11:7];
    assign imm = {{(XLEN-12){bus.Instr[31]}}, bus.Instr[31:20]};

    alu_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk(Clk), .rst(Reset), .we(bus.WbEn), .waddr(bus.WbAddr), .wdata(bus.WbData),
        .raddr1(rs1), .raddr2(rs2), .rdata1(rdata1), .rdata2(rdata2)
    );

    // A source retired by this cycle's writeback is no longer a hazard; the regfile bypasses it.
    assign busy1 = pending[rs1] && !(bus.WbEn && bus.WbAddr == rs1);
    assign busy2 = pending[rs2] && !(bus.WbEn && bus.WbAddr == rs2);
    assign hazard = dec.legal && (busy1 || (dec.is_r && busy2));
    assign bus.InstrReady = !Reset && (!bus.AluValid || bus.AluReady) && !hazard;
    assign accept = bus.InstrValid && bus.InstrReady;
    assign issue = accept && dec.legal;

    always_comb begin
        pending_nx = pending;
        if (bus.WbEn) pending_nx[bus.WbAddr] = 1'b0;
        if (issue && rd != '0) pending_nx[rd] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.AluValid <= 1'b0;
            bus.Control <= ALU_AND;
            bus.Operand1 <= '0;
            bus.Operand2 <= '0;
            bus.Rd <= '0;
            bus.IllegalInstr <= 1'b0;
            pending <= '0;
        end else begin
            bus.IllegalInstr <= accept && !dec.legal;
            pending <= pending_nx;
            if (issue) begin
                bus.AluValid <= 1'b1;
                bus.Control <= dec.ctrl;
                bus.Operand1 <= rdata1;
                bus.Operand2 <= dec.is_r ? rdata2 : imm;
                bus.Rd <= rd;
            end else if (bus.AluReady) begin
                bus.AluValid <= 1'b0;
            end
        end
    end
endmodule
